// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: bundles the sequencer's memory, MAC and result-port
// signals.
//   master : sequencer side. It drives the addresses, the MAC operands and
//            the result port, and receives read data, the MAC sum and
//            res_ready.
//   slave  : environment side (ROMs, MAC instance, result consumer).
interface mac_sequencer_if #(
    parameter int DATA_W = 128,
    parameter int SUM_W  = 20,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] p_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] p_rdata;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] mac_p;
    logic [DATA_W-1:0] mac_w;
    logic [SUM_W-1:0]  mac_s;
    logic [ACC_W-1:0]  res_data;
    logic [ADDR_W-1:0] res_idx;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output p_addr, w_addr, mac_p, mac_w, res_data, res_idx, res_valid,
        input  p_rdata, w_rdata, mac_s, res_ready
    );

    modport slave (
        input  p_addr, w_addr, mac_p, mac_w, res_data, res_idx, res_valid,
        output p_rdata, w_rdata, mac_s, res_ready
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: steps the 128-bit MAC through a whole neuron layer.
// For each neuron it streams WORDS pixel/weight word pairs from the two
// synchronous-read ROMs into the MAC and accumulates the sums, saturating
// at 2^ACC_W-1. It then offers the neuron total on a valid/ready port.
// Ports:
//   clk, rst_n : clock (rising edge) and async active-low reset
//   start_i    : one-cycle pulse that begins a layer pass
//   busy_o     : high while a pass is in progress
//   done_o     : one-cycle pulse after the last result is accepted
//   bus        : memory addresses/data, MAC operands/sum, result port
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one pixel/weight address pair per cycle, words 0..WORDS-1
// DRAIN | waiting for the tagged words to reach the accumulator
// OUT   | result presented, waiting for res_ready
module mac_sequencer #(
    parameter int DATA_W  = 128,
    parameter int SUM_W   = 20,
    parameter int ACC_W   = 24,
    parameter int ADDR_W  = 8,
    parameter int WORDS   = 4,
    parameter int NEURONS = 10,
    parameter int MAC_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    mac_sequencer_if.master bus
);
    // An address issued at edge t yields rdata at t+1, operands at t+2 and
    // a sampled sum at t+L.
    localparam int L = 2 + MAC_LAT;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] p_addr_q, p_addr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [ADDR_W-1:0] w_next_q, w_next_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] neuron_q, neuron_d;
    logic [DATA_W-1:0] mac_p_q, mac_p_d;
    logic [DATA_W-1:0] mac_w_q, mac_w_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  res_data_q, res_data_d;
    logic [ADDR_W-1:0] res_idx_q, res_idx_d;
    logic              res_valid_q, res_valid_d;
    logic [L-1:0]      tag_q, tag_d;
    logic              issue;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_sat;

    // One extra bit catches the overflow, which clamps the sum to all ones.
    always_comb begin
        acc_sum = {1'b0, acc_q} + (ACC_W+1)'(bus.mac_s);
        acc_sat = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        p_addr_d    = p_addr_q;
        w_addr_d    = w_addr_q;
        w_next_d    = w_next_q;
        word_d      = word_q;
        neuron_d    = neuron_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_valid_d = res_valid_q;
        issue       = 1'b0;
        // Untagged slots present zero operands, so the MAC sees bubbles as 0.
        mac_p_d     = tag_q[1] ? bus.p_rdata : '0;
        mac_w_d     = tag_q[1] ? bus.w_rdata : '0;
        acc_d       = tag_q[L-1] ? acc_sat : acc_q;

        case (state_q)
            S_IDLE: begin
                // done_q is high only in the cycle after a pass ends; a start
                // in that cycle is dropped.
                if (start_i && !done_q) begin
                    state_d  = S_ISSUE;
                    busy_d   = 1'b1;
                    word_d   = '0;
                    neuron_d = '0;
                    w_next_d = '0;
                    acc_d    = '0;
                end
            end
            S_ISSUE: begin
                issue    = 1'b1;
                p_addr_d = word_q;
                w_addr_d = w_next_q;
                w_next_d = w_next_q + ADDR_W'(1);
                if (word_q == ADDR_W'(WORDS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    word_d = word_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (tag_q == '0) begin
                    res_data_d  = acc_q;
                    res_idx_d   = neuron_q;
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (neuron_q == ADDR_W'(NEURONS - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        neuron_d = neuron_q + ADDR_W'(1);
                        word_d   = '0;
                        acc_d    = '0;
                        state_d  = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        tag_d = {tag_q[L-2:0], issue};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            p_addr_q    <= '0;
            w_addr_q    <= '0;
            w_next_q    <= '0;
            word_q      <= '0;
            neuron_q    <= '0;
            mac_p_q     <= '0;
            mac_w_q     <= '0;
            acc_q       <= '0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            p_addr_q    <= p_addr_d;
            w_addr_q    <= w_addr_d;
            w_next_q    <= w_next_d;
            word_q      <= word_d;
            neuron_q    <= neuron_d;
            mac_p_q     <= mac_p_d;
            mac_w_q     <= mac_w_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_valid_q <= res_valid_d;
            tag_q       <= tag_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign bus.p_addr    = p_addr_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.mac_p     = mac_p_q;
    assign bus.mac_w     = mac_w_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;
    assign bus.res_valid = res_valid_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: drives random ROM contents, a behavioural MAC and
// randomized res_ready timing into mac_sequencer. Each neuron result is
// compared against a reference sum computed directly from the ROM arrays.
// A second instance (ACC_W=21, one neuron) with a constant-sum MAC stub
// exercises accumulator saturation.
module tb_mac_sequencer;
    localparam int DATA_W  = 128;
    localparam int SUM_W   = 20;
    localparam int ACC_W   = 24;
    localparam int ADDR_W  = 8;
    localparam int WORDS   = 4;
    localparam int NEURONS = 10;
    localparam int MAC_LAT = 1;
    localparam int S_ACC_W = 21;
    localparam int LAT     = 1 + WORDS + 2 + MAC_LAT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;
    logic s_start = 1'b0;
    logic s_busy, s_done;
    logic [SUM_W-1:0] s_val = '0;
    int n_chk    = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [DATA_W-1:0] pmem [256];
    logic [DATA_W-1:0] wmem [256];

    mac_sequencer_if #(.DATA_W(DATA_W), .SUM_W(SUM_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();
    mac_sequencer_if #(.DATA_W(DATA_W), .SUM_W(SUM_W), .ACC_W(S_ACC_W), .ADDR_W(ADDR_W)) sbus ();

    mac_sequencer #(
        .DATA_W(DATA_W), .SUM_W(SUM_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W),
        .WORDS(WORDS), .NEURONS(NEURONS), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .bus(bus)
    );

    mac_sequencer #(
        .DATA_W(DATA_W), .SUM_W(SUM_W), .ACC_W(S_ACC_W), .ADDR_W(ADDR_W),
        .WORDS(WORDS), .NEURONS(1), .MAC_LAT(MAC_LAT)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .busy_o(s_busy), .done_o(s_done), .bus(sbus)
    );

    always #5 clk = ~clk;

    function automatic logic [SUM_W-1:0] mac16(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] w);
        int s = 0;
        for (int b = 0; b < 16; b++) s += int'(p[8*b +: 8]) * int'(w[8*b +: 8]);
        return SUM_W'(s);
    endfunction

    always_ff @(posedge clk) begin
        bus.p_rdata  <= pmem[bus.p_addr];
        bus.w_rdata  <= wmem[bus.w_addr];
        sbus.p_rdata <= pmem[sbus.p_addr] | DATA_W'(1);
        sbus.w_rdata <= wmem[sbus.w_addr];
        if (done) done_cnt <= done_cnt + 1;
    end

    always_comb bus.mac_s  = mac16(bus.mac_p, bus.mac_w);
    always_comb sbus.mac_s = (sbus.mac_p != '0) ? s_val : '0;

    // Neuron n total: sum over every word and byte lane of pixel*weight.
    function automatic logic [ACC_W-1:0] ref_sum(input int n);
        longint tot = 0;
        for (int w = 0; w < WORDS; w++)
            for (int b = 0; b < 16; b++)
                tot += longint'(pmem[w][8*b +: 8]) * longint'(wmem[n*WORDS + w][8*b +: 8]);
        if (tot > (longint'(1) << ACC_W) - 1) return '1;
        return ACC_W'(tot);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) begin
            pmem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            wmem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_res_valid"}, bus.res_valid, 0);
        check({pfx, "_p_addr"}, bus.p_addr, 0);
        check({pfx, "_w_addr"}, bus.w_addr, 0);
        check({pfx, "_mac_p"}, bus.mac_p, 0);
        check({pfx, "_mac_w"}, bus.mac_w, 0);
        check({pfx, "_res_data"}, bus.res_data, 0);
        check({pfx, "_res_idx"}, bus.res_idx, 0);
    endtask

    // bp_n: neuron held under 5 cycles of backpressure; bs_n: neuron during
    // which a stray start is pulsed; abort_n: neuron whose issue is cut by reset.
    task automatic run_pass(input int bp_n, input int bs_n, input int abort_n);
        int cyc = 0;
        int hold;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < NEURONS; n++) begin
            while (!bus.res_valid && cyc < 64) begin
                start = (n == bs_n && cyc == 2);
                if (n == abort_n && cyc == 2) begin
                    #2 rst_n = 1'b0;
                    #1 check_zero("rst_mid");
                    @(negedge clk); rst_n = 1'b1;
                    return;
                end
                @(negedge clk); cyc++;
            end
            start = 1'b0;
            if (cyc >= 64) begin
                check("res_valid_timeout", 0, 1);
                return;
            end
            check("latency", cyc, LAT);
            check("res_idx", bus.res_idx, n);
            check("res_data", bus.res_data, ref_sum(n));
            check("w_addr_held", bus.w_addr, n*WORDS + WORDS - 1);
            check("p_addr_held", bus.p_addr, WORDS - 1);
            hold = (n == bp_n) ? 5 : $urandom_range(0, 2);
            repeat (hold) begin
                @(negedge clk);
                check("bp_valid", bus.res_valid, 1);
                check("bp_data", bus.res_data, ref_sum(n));
                check("bp_idx", bus.res_idx, n);
                check("bp_w_addr", bus.w_addr, n*WORDS + WORDS - 1);
            end
            bus.res_ready = 1'b1;
            @(negedge clk);
            bus.res_ready = 1'b0;
            check("res_valid_drop", bus.res_valid, 0);
            cyc = 0;
            if (n == NEURONS - 1) begin
                check("done_pulse", done, 1);
                check("busy_end", busy, 0);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("done_single", done, 0);
                check("start_on_done_ignored", busy, 0);
                check("mac_p_bubble", bus.mac_p, 0);
            end else begin
                check("done_quiet", done, 0);
                check("busy_mid", busy, 1);
                if (n == bp_n) begin
                    @(negedge clk); cyc = 1;
                    check("next_issue_w", bus.w_addr, (n + 1) * WORDS);
                    check("next_issue_p", bus.p_addr, 0);
                end
            end
        end
    endtask

    task automatic run_sat(input logic [SUM_W-1:0] v);
        int cyc = 0;
        longint exp = longint'(v) * WORDS;
        if (exp > (longint'(1) << S_ACC_W) - 1) exp = (longint'(1) << S_ACC_W) - 1;
        s_val = v;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        while (!sbus.res_valid && cyc < 64) begin
            @(negedge clk); cyc++;
        end
        check("sat_latency", cyc, LAT);
        check("sat_data", sbus.res_data, exp);
        check("sat_idx", sbus.res_idx, 0);
        sbus.res_ready = 1'b1;
        @(negedge clk);
        sbus.res_ready = 1'b0;
        check("sat_done", s_done, 1);
        check("sat_busy", s_busy, 0);
        @(negedge clk);
        check("sat_done_clear", s_done, 0);
    endtask

    initial begin
        bus.res_ready  = 1'b0;
        sbus.res_ready = 1'b0;
        fill_mem();
        #3 check_zero("reset");
        #10 rst_n = 1'b1;
        run_sat(20'h00010);
        run_sat(20'hFFFFF);
        run_pass(2, 4, -1);
        fill_mem();
        run_pass(-1, -1, 5);
        fill_mem();
        run_pass(-1, 1, -1);
        @(negedge clk);
        check("done_count", done_cnt, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
